fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the decoder.
- Keeps the PC and issues single-outstanding requests to instruction memory over a stb/ack handshake.
- Buffers returned words with their PC in a 2-entry FIFO and presents them to the decoder as instr/pc/ce.
- Honours decoder stall and accepts redirect/flush from execute.

---
 rtl/fetch_stage.sv | 133 +++++++++++++
 tb/tb_fetch_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding memory requests,
// and a 2-entry {pc, instr} buffer feeding the decoder.
module fetch_stage #(
    parameter int                  PC_WIDTH = 32,
    parameter int                  IWIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                f_clk,
    input  logic                f_rst,
    output logic [PC_WIDTH-1:0] f_o_iaddr,
    output logic                f_o_stb,
    input  logic                f_i_ack,
    input  logic [IWIDTH-1:0]   f_i_rdata,
    output logic [IWIDTH-1:0]   f_o_instr,
    output logic [PC_WIDTH-1:0] f_o_pc,
    output logic                f_o_ce,
    input  logic                f_i_stall,
    input  logic                f_i_change_pc,
    input  logic [PC_WIDTH-1:0] f_i_new_pc,
    input  logic                f_i_flush
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DRAIN
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] drain_addr;
    logic [PC_WIDTH-1:0] pc_mem  [2];
    logic [IWIDTH-1:0]   ins_mem [2];
    logic                rd_ptr;
    logic                wr_ptr;
    logic [1:0]          cnt;
    logic [1:0]          cnt_nx;
    logic                redirect;
    logic                wr_en;
    logic                pop;
    logic                unused_bits;

    assign unused_bits = ^f_i_new_pc[1:0];

    // Flush is a redirect that keeps the PC.
    assign redirect = f_i_change_pc | f_i_flush;
    assign wr_en    = (state == S_REQ) && f_i_ack && !redirect;
    assign pop      = f_o_ce && !f_i_stall && !redirect;
    assign cnt_nx   = redirect ? 2'd0
                    : cnt + {1'b0, wr_en} - {1'b0, pop};

    always_ff @(posedge f_clk) begin
        if (f_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (cnt_nx < 2'd2) state_nx = S_REQ;
            end
            S_REQ: begin
                if (redirect) begin
                    state_nx = f_i_ack ? S_REQ : S_DRAIN;
                end else if (f_i_ack) begin
                    state_nx = (cnt_nx < 2'd2) ? S_REQ : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (f_i_ack) state_nx = S_REQ;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        f_o_stb   = (state != S_IDLE);
        f_o_iaddr = (state == S_DRAIN) ? drain_addr : pc;
    end

    always_ff @(posedge f_clk) begin
        if (f_rst) begin
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
        end else begin
            if (f_i_change_pc) begin
                pc <= {f_i_new_pc[PC_WIDTH-1:2], 2'b00};
            end else if (wr_en) begin
                pc <= pc + PC_WIDTH'(4);
            end
            // Abandoned request keeps its address until memory answers.
            if (state == S_REQ && redirect && !f_i_ack) begin
                drain_addr <= pc;
            end
        end
    end

    always_ff @(posedge f_clk) begin
        if (f_rst) begin
            cnt    <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                pc_mem[i]  <= '0;
                ins_mem[i] <= '0;
            end
        end else if (redirect) begin
            cnt    <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            cnt <= cnt_nx;
            if (wr_en) begin
                pc_mem[wr_ptr]  <= pc;
                ins_mem[wr_ptr] <= f_i_rdata;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    assign f_o_ce    = (cnt != 2'd0);
    assign f_o_instr = ins_mem[rd_ptr];
    assign f_o_pc    = pc_mem[rd_ptr];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table, directed corner sequences,
// and a randomized run against a queue-based reference model.
module tb_fetch_stage;

    logic        f_clk = 1'b0;
    logic        f_rst = 1'b1;
    logic [31:0] f_o_iaddr;
    logic        f_o_stb;
    logic        f_i_ack = 1'b0;
    logic [31:0] f_i_rdata = '0;
    logic [31:0] f_o_instr;
    logic [31:0] f_o_pc;
    logic        f_o_ce;
    logic        f_i_stall = 1'b0;
    logic        f_i_change_pc = 1'b0;
    logic [31:0] f_i_new_pc = '0;
    logic        f_i_flush = 1'b0;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    fetch_stage dut (
        .f_clk         (f_clk),
        .f_rst         (f_rst),
        .f_o_iaddr     (f_o_iaddr),
        .f_o_stb       (f_o_stb),
        .f_i_ack       (f_i_ack),
        .f_i_rdata     (f_i_rdata),
        .f_o_instr     (f_o_instr),
        .f_o_pc        (f_o_pc),
        .f_o_ce        (f_o_ce),
        .f_i_stall     (f_i_stall),
        .f_i_change_pc (f_i_change_pc),
        .f_i_new_pc    (f_i_new_pc),
        .f_i_flush     (f_i_flush)
    );

    always #5 f_clk = ~f_clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    typedef struct {
        logic        st;
        logic        ak;
        logic        chg;
        logic        fl;
        logic [31:0] npc;
        logic        e_stb;
        logic [31:0] e_addr;
        logic        e_ce;
        logic [31:0] e_pc;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_deliv = 0;
    ent_t        mq[$];
    logic [31:0] mpc;
    logic        drop;
    logic        hold;
    logic [31:0] hold_addr;
    vec_t        vt[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string name, input logic stb,
                              input logic [31:0] addr, input logic ce,
                              input logic [31:0] pc);
        chk({name, "_stb"}, f_o_stb, stb);
        chk({name, "_iaddr"}, f_o_iaddr, addr);
        chk({name, "_ce"}, f_o_ce, ce);
        if (ce) begin
            chk({name, "_pc"}, f_o_pc, pc);
            chk({name, "_instr"}, f_o_instr, pc ^ KEY);
        end
    endtask

    task automatic do_reset();
        f_rst = 1'b1;
        f_i_ack = 1'b0;
        f_i_stall = 1'b0;
        f_i_change_pc = 1'b0;
        f_i_flush = 1'b0;
        @(posedge f_clk);
        #1;
        f_rst = 1'b0;
        mq.delete();
        mpc  = 32'h0;
        drop = 1'b0;
        hold = 1'b0;
    endtask

    // One clock: check DUT against the model, drive inputs, advance model.
    task automatic cycle(input logic st, input logic ak, input logic chg,
                         input logic [31:0] npc, input logic fl);
        logic        s_stb;
        logic        s_ce;
        logic [31:0] s_addr;
        logic        acked;
        s_stb  = f_o_stb;
        s_ce   = f_o_ce;
        s_addr = f_o_iaddr;
        chk("m_ce", {31'b0, s_ce}, {31'b0, mq.size() != 0});
        if (mq.size() != 0) begin
            chk("m_pc", f_o_pc, mq[0].pc);
            chk("m_instr", f_o_instr, mq[0].ins);
        end
        if (hold) begin
            chk("m_stb_hold", {31'b0, s_stb}, 32'd1);
            chk("m_addr_hold", s_addr, hold_addr);
        end
        f_i_stall     = st;
        f_i_change_pc = chg;
        f_i_new_pc    = npc;
        f_i_flush     = fl;
        acked         = s_stb & ak;
        f_i_ack       = acked;
        f_i_rdata     = s_addr ^ KEY;
        if (acked && !drop && !chg && !fl) chk("m_fetch_addr", s_addr, mpc);
        @(posedge f_clk);
        #1;
        f_i_ack   = 1'b0;
        hold      = s_stb && !acked;
        hold_addr = s_addr;
        if (chg || fl) begin
            drop = s_stb && !acked;
            mq.delete();
            if (chg) mpc = {npc[31:2], 2'b00};
        end else begin
            if (s_ce && !st) begin
                void'(mq.pop_front());
                n_deliv++;
            end
            if (acked) begin
                if (drop) begin
                    drop = 1'b0;
                end else begin
                    mq.push_back('{mpc, s_addr ^ KEY});
                    mpc = mpc + 32'd4;
                end
            end
        end
    endtask

    initial begin
        vt[0] = '{0, 1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0};
        vt[1] = '{0, 1, 0, 0, 32'h0, 1, 32'h0, 0, 32'h0};
        vt[2] = '{1, 1, 0, 0, 32'h0, 1, 32'h4, 1, 32'h0};
        vt[3] = '{1, 1, 0, 0, 32'h0, 0, 32'h8, 1, 32'h0};
        vt[4] = '{0, 1, 0, 0, 32'h0, 0, 32'h8, 1, 32'h0};
        vt[5] = '{0, 1, 0, 0, 32'h0, 1, 32'h8, 1, 32'h4};
        vt[6] = '{0, 1, 0, 0, 32'h0, 1, 32'hC, 1, 32'h8};
        vt[7] = '{0, 1, 0, 0, 32'h0, 1, 32'h10, 1, 32'hC};

        do_reset();
        chk("rst_instr", f_o_instr, 32'h0);
        chk("rst_pc", f_o_pc, 32'h0);
        for (int i = 0; i < 8; i++) begin
            expect_out($sformatf("vec%0d", i), vt[i].e_stb, vt[i].e_addr,
                       vt[i].e_ce, vt[i].e_pc);
            cycle(vt[i].st, vt[i].ak, vt[i].chg, vt[i].npc, vt[i].fl);
        end

        // Redirect while the request at 0x8 waits for its ack.
        do_reset();
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        expect_out("rd_pre", 1, 32'h8, 1, 32'h4);
        cycle(0, 0, 1, 32'h100, 0);
        expect_out("rd_w1", 1, 32'h8, 0, 0);
        cycle(0, 0, 0, 0, 0);
        expect_out("rd_w2", 1, 32'h8, 0, 0);
        cycle(0, 0, 0, 0, 0);
        expect_out("rd_w3", 1, 32'h8, 0, 0);
        cycle(0, 1, 0, 0, 0);
        expect_out("rd_new", 1, 32'h100, 0, 0);
        cycle(0, 1, 0, 0, 0);
        expect_out("rd_first", 1, 32'h104, 1, 32'h100);

        // Redirect coincident with an ack.
        cycle(0, 1, 1, 32'h203, 0);
        expect_out("rda", 1, 32'h200, 0, 0);

        // Flush with two buffered entries.
        cycle(1, 1, 1, 32'h10, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        expect_out("fl_pre", 0, 32'h18, 1, 32'h10);
        cycle(1, 0, 0, 0, 1);
        expect_out("fl_post", 1, 32'h18, 0, 0);

        // Reset in the middle of a request.
        cycle(1, 1, 0, 0, 0);
        expect_out("mr_pre", 1, 32'h1C, 1, 32'h18);
        do_reset();
        expect_out("mr_rst", 0, 32'h0, 0, 0);
        chk("mr_instr", f_o_instr, 32'h0);
        chk("mr_pc", f_o_pc, 32'h0);
        cycle(0, 1, 0, 0, 0);
        expect_out("mr_restart", 1, 32'h0, 0, 0);

        // PC wrap-around and low-bit masking of the target.
        cycle(0, 1, 1, 32'hFFFF_FFFF, 0);
        expect_out("wr_top", 1, 32'hFFFF_FFFC, 0, 0);
        cycle(0, 1, 0, 0, 0);
        expect_out("wr_zero", 1, 32'h0, 1, 32'hFFFF_FFFC);

        n_deliv = 0;
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] npc;
            npc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF))
                                                : $urandom();
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                      $urandom_range(0, 39) == 0, npc,
                      $urandom_range(0, 49) == 0);
            end
        end
        chk("rand_progress", {31'b0, n_deliv > 1000}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
